// File: rtl/prime_scan_ctrl.sv
// Sweeps candidates lo..hi through an external prime detector, queues each prime
// in a small FIFO for a valid/ready consumer and counts the primes found.
module prime_scan_ctrl #(
   parameter int W     = 4,
   parameter int DEPTH = 4,
   parameter int CW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  lo,
   input  logic [W-1:0]  hi,
   output logic [W-1:0]  cand,
   input  logic          prime,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] cnt,
   output logic [W-1:0]  q_data,
   output logic          q_valid,
   input  logic          q_ready
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  cand_q, cand_d;
   logic [W-1:0]  hi_q, hi_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          full, empty, push, pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop   = !empty && q_ready;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               hi_d  = hi;
               if (lo <= hi) begin
                  cand_d  = lo;
                  state_d = SCAN;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SCAN: begin
            // full is taken from registered pointers, so a same-cycle pop cannot unblock a push.
            if (!(prime && full)) begin
               if (prime) begin
                  push  = 1'b1;
                  cnt_d = cnt_q + CW'(1);
               end
               if (cand_q == hi_q) begin
                  state_d = DONE;
               end else begin
                  cand_d = cand_q + W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cand_q  <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cand_q;
            wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   assign cand    = cand_q;
   assign cnt     = cnt_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign q_valid = !empty;
   assign q_data  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Bench for prime_scan_ctrl: models the prime detector, keeps a scoreboard of
// expected FIFO pops and checks scan timing, counts, stalls and reset.
module tb_prime_scan_ctrl;
   localparam int W = 4, DEPTH = 4, CW = 5;

   logic          clk = 1'b0;
   logic          rst, start, prime, busy, done, q_valid, q_ready;
   logic [W-1:0]  lo, hi, cand, q_data;
   logic [CW-1:0] cnt;

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int done_pulses = 0;
   int sb_q [$];

   typedef struct {
      int lo;
      int hi;
      int exp_cnt;
      int exp_done;
   } vec_t;
   vec_t vecs [7];

   prime_scan_ctrl #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .cand(cand),
      .prime(prime), .busy(busy), .done(done), .cnt(cnt),
      .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready)
   );

   always #5 clk = ~clk;

   function automatic logic is_prime(input int v);
      if (v < 2) return 1'b0;
      for (int d = 2; d < v; d++) if (v % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   assign prime = is_prime(int'(cand));

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) if (done) done_pulses++;

   // Scoreboard: compare each accepted head entry against the oldest expected prime.
   always @(negedge clk) begin
      if (!rst && q_valid && q_ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected actual=%0d required=none", q_data);
         end else begin
            check("pop_data", int'(q_data), sb_q[0]);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic expect_primes(input int l, input int h);
      for (int v = l; v <= h; v++) if (is_prime(v)) sb_q.push_back(v);
   endtask

   // Pulses start with lo/hi and waits for done; returns the done cycle relative to the start cycle.
   task automatic run_scan(input int l, input int h, input int budget, input bit chk_cand,
                           output int done_rel, output int cand_before);
      int c0, cand_err;
      expect_primes(l, h);
      @(posedge clk); #1;
      cand_before = int'(cand);
      lo = W'(l); hi = W'(h); start = 1'b1; c0 = cycle;
      @(posedge clk); #1;
      start = 1'b0;
      done_rel = -1;
      cand_err = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            done_rel = cycle - c0;
            break;
         end
         if (int'(cand) != ((l + (cycle - c0) - 1) & 15)) cand_err++;
      end
      if (chk_cand) check("cand_step_errors", cand_err, 0);
   endtask

   initial begin
      int done_rel, cand_before, dc0, c0;

      vecs[0] = '{lo: 0,  hi: 15, exp_cnt: 6, exp_done: 17};
      vecs[1] = '{lo: 13, hi: 13, exp_cnt: 1, exp_done: 2};
      vecs[2] = '{lo: 8,  hi: 10, exp_cnt: 0, exp_done: 4};
      vecs[3] = '{lo: 9,  hi: 3,  exp_cnt: 0, exp_done: 1};
      vecs[4] = '{lo: 14, hi: 15, exp_cnt: 0, exp_done: 3};
      vecs[5] = '{lo: 4,  hi: 7,  exp_cnt: 2, exp_done: 5};
      vecs[6] = '{lo: 2,  hi: 3,  exp_cnt: 2, exp_done: 3};

      rst = 1'b1; start = 1'b0; lo = '0; hi = '0; q_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", cnt, 0);
      check("rst_cand", cand, 0);
      check("rst_q_valid", q_valid, 0);
      check("rst_q_data", q_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q_ready = 1'b1;

      for (int i = 0; i < 7; i++) begin
         dc0 = done_pulses;
         run_scan(vecs[i].lo, vecs[i].hi, 40, vecs[i].lo <= vecs[i].hi, done_rel, cand_before);
         check($sformatf("v%0d_done_cycle", i), done_rel, vecs[i].exp_done);
         check($sformatf("v%0d_cnt", i), cnt, vecs[i].exp_cnt);
         @(negedge clk);
         check($sformatf("v%0d_busy_low", i), busy, 0);
         check($sformatf("v%0d_cand_final", i), cand,
               (vecs[i].lo <= vecs[i].hi) ? vecs[i].hi : cand_before);
         repeat (6) @(negedge clk);
         check($sformatf("v%0d_sb_left", i), sb_q.size(), 0);
         check($sformatf("v%0d_q_valid", i), q_valid, 0);
         check($sformatf("v%0d_done_pulses", i), done_pulses - dc0, 1);
         check($sformatf("v%0d_cnt_hold", i), cnt, vecs[i].exp_cnt);
      end

      // FIFO fills with 2,3,5,7 and the scan stalls on candidate 11.
      q_ready = 1'b0;
      dc0 = done_pulses;
      expect_primes(0, 15);
      @(posedge clk); #1;
      lo = 4'd0; hi = 4'd15; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (25) @(negedge clk);
      check("stall_cand", cand, 11);
      check("stall_busy", busy, 1);
      check("stall_q_valid", q_valid, 1);
      check("stall_head", q_data, 2);
      check("stall_cnt", cnt, 4);
      check("stall_no_done", done_pulses - dc0, 0);
      @(posedge clk); #1;
      q_ready = 1'b1;
      done_rel = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) begin
            done_rel = k;
            break;
         end
      end
      check("stall_done_seen", done_rel >= 0, 1);
      check("stall_cnt_final", cnt, 6);
      repeat (6) @(negedge clk);
      check("stall_sb_left", sb_q.size(), 0);
      check("stall_done_pulses", done_pulses - dc0, 1);

      // Start ignored while busy, then asynchronous reset mid-scan with entries queued.
      q_ready = 1'b0;
      expect_primes(0, 15);
      @(posedge clk); #1;
      lo = 4'd0; hi = 4'd15; start = 1'b1; c0 = cycle;
      @(posedge clk); #1;
      start = 1'b0;
      while (cycle - c0 < 6) begin
         @(posedge clk); #1;
      end
      lo = 4'd9; hi = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_start_cnt", cnt, 3);
      check("busy_start_cand", cand, 6);
      check("busy_start_busy", busy, 1);
      check("busy_start_q_valid", q_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_q_valid", q_valid, 0);
      check("arst_cnt", cnt, 0);
      check("arst_cand", cand, 0);
      check("arst_q_data", q_data, 0);
      sb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      q_ready = 1'b1;

      run_scan(2, 3, 40, 1'b1, done_rel, cand_before);
      check("post_rst_done_cycle", done_rel, 3);
      check("post_rst_cnt", cnt, 2);
      repeat (6) @(negedge clk);
      check("post_rst_sb_left", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
